// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with architectural
// Hi/Lo registers. Signed operands are reduced to magnitudes on Start,
// processed one bit per cycle, and the result signs are applied in a
// single FIX cycle before Hi/Lo are updated and Done pulses.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] HiIn,
    input  logic [WIDTH-1:0] LoIn,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0]     ZERO_W   = '0;

    // Two's-complement magnitude for signed operands, pass-through otherwise.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                              input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            mag_f = (~v) + ONE_W;
        end else begin
            mag_f = v;
        end
    endfunction

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // quotient/product sign
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;       // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;           // product, or quotient in low half
    logic [WIDTH-1:0]   rem_q, rem_d;           // partial remainder
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               sign_a_s, sign_b_s;

    // Register every piece of state; synchronous reset aborts any operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    // Next-state logic: operand capture, one radix-2 step per CALC cycle,
    // sign fix-up and Hi/Lo update in FIX, mthi/mtlo only when idle.
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        sign_a_s    = (~Op[0]) & A[WIDTH-1];
        sign_b_s    = (~Op[0]) & B[WIDTH-1];
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, b_mag_q} : {1'b0, ZERO_W});
        div_shift_s = {rem_q, acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_mag_q};
        prod_s      = neg_res_q ? ((~acc_q) + ONE_2W) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    is_div_d  = Op[1];
                    neg_res_d = sign_a_s ^ sign_b_s;
                    neg_rem_d = sign_a_s;
                    b_mag_d   = mag_f(B, ~Op[0]);
                    acc_d     = {ZERO_W, mag_f(A, ~Op[0])};
                    rem_d     = ZERO_W;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_CALC;
                end else begin
                    if (HiWrite) begin
                        hi_d = HiIn;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (LoWrite) begin
                        lo_d = LoIn;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (!div_diff_s[WIDTH]) begin
                        rem_d = div_diff_s[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift_s[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (is_div_q) begin
                    if (b_mag_q == ZERO_W) begin
                        divzero_d = 1'b1;
                    end else begin
                        lo_d = neg_res_q ? ((~acc_q[WIDTH-1:0]) + ONE_W) : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? ((~rem_q) + ONE_W) : rem_q;
                    end
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): table of directed
// multiply/divide vectors plus hand sequences for Hi/Lo preload, divide
// by zero, ignored Start/HiWrite while busy, Start in the Done cycle and
// a mid-operation reset.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01,
                           OP_DIV = 2'b10,  OP_DIVU  = 2'b11;

    logic         Clk = 1'b0, Reset, Start, HiWrite, LoWrite;
    logic [1:0]   Op;
    logic [W-1:0] A, B, HiIn, LoIn, Hi, Lo;
    logic         Busy, Done, DivZero;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .HiIn(HiIn), .LoIn(LoIn),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start an op from the current (negedge) time and follow it cycle by
    // cycle. exp_done is the cycle index of Done after the Start cycle
    // (0 = Done must never appear). inject_at issues a Start+HiWrite while
    // busy; reset_at pulses Reset for one cycle.
    task automatic do_op(input string name, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int exp_done,
                         input int inject_at, input int reset_at);
        int done_at = 0;
        int busy_cnt = 0;
        logic [W-1:0] got_hi = '0, got_lo = '0;
        logic got_dz = 1'b0;
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (Busy) busy_cnt++;
            if (Done && done_at == 0) begin
                done_at = i; got_hi = Hi; got_lo = Lo; got_dz = DivZero;
            end
            if (reset_at != 0 && i == reset_at + 1) begin
                Reset = 1'b0;
                check({name, "_rst_busy"}, {63'd0, Busy}, 64'd0);
                check({name, "_rst_hi"}, {32'd0, Hi}, 64'd0);
                check({name, "_rst_lo"}, {32'd0, Lo}, 64'd0);
            end
            if (reset_at != 0 && i == reset_at) Reset = 1'b1;
            if (inject_at != 0 && i == inject_at + 1) begin
                Start = 1'b0; HiWrite = 1'b0;
            end
            if (inject_at != 0 && i == inject_at) begin
                Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
                HiWrite = 1'b1; HiIn = 32'h0000DEAD;
            end
            if (done_at != 0) break;
            @(negedge Clk);
        end
        check({name, "_done_cycle"}, 64'(done_at), 64'(exp_done));
        if (exp_done != 0) begin
            check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
            check({name, "_hi"}, {32'd0, got_hi}, {32'd0, ehi});
            check({name, "_lo"}, {32'd0, got_lo}, {32'd0, elo});
            check({name, "_divzero"}, {63'd0, got_dz}, {63'd0, edz});
        end
    endtask

    initial begin
        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[5] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[8] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; HiIn = '0; LoIn = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        check("reset_divzero", {63'd0, DivZero}, 64'd0);
        check("reset_hi", {32'd0, Hi}, 64'd0);
        check("reset_lo", {32'd0, Lo}, 64'd0);

        for (int v = 0; v < 9; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].b,
                  vecs[v].hi, vecs[v].lo, vecs[v].dz, W + 2, 0, 0);
            @(negedge Clk);
        end

        // mthi/mtlo in the same cycle, then divide by zero keeps them
        HiWrite = 1'b1; LoWrite = 1'b1; HiIn = 32'h11; LoIn = 32'h22;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        check("preload_hi", {32'd0, Hi}, 64'h11);
        check("preload_lo", {32'd0, Lo}, 64'h22);
        do_op("div0", OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, W + 2, 0, 0);
        @(negedge Clk);
        check("post_done_divzero", {63'd0, DivZero}, 64'd0);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, W + 2, 0, 0);
        @(negedge Clk);

        // Start/HiWrite while busy ignored, then Start in the Done cycle
        do_op("busy_ign", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, W + 2, 5, 0);
        do_op("start_in_done", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, W + 2, 0, 0);
        @(negedge Clk);

        // Reset mid-operation: Hi/Lo cleared, no Done afterwards
        do_op("mid_reset", OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 0, 0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
